// File: rtl/uart_row_writer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_row_writer_pkg                                          |
// | Description : State encodings, response codes and framing helpers shared   |
// |               by the UART row writer.                                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_row_writer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_row_lo  = 3'd1;
    localparam state_t c_st_payload = 3'd2;
    localparam state_t c_st_discard = 3'd3;
    localparam state_t c_st_csum    = 3'd4;
    localparam state_t c_st_trailer = 3'd5;
    localparam state_t c_st_resp    = 3'd6;

    localparam logic [7:0] c_resp_ack  = 8'hAA;
    localparam logic [7:0] c_resp_row  = 8'hE1;
    localparam logic [7:0] c_resp_end  = 8'hE2;
    localparam logic [7:0] c_resp_tmo  = 8'hE3;
    localparam logic [7:0] c_resp_csum = 8'hE4;

    function automatic int f_ppb(input int pix_w);
        return 8 / pix_w;
    endfunction

    function automatic int f_nb(input int width, input int pix_w);
        return (width + f_ppb(pix_w) - 1) / f_ppb(pix_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_row_writer_pixel_unpacker.sv
// +----------------------------------------------------------------------------+
// | Module      : pixel_unpacker                                               |
// | Description : Splits payload bytes into LSB-first pixels, one RAM write    |
// |               per cycle, dropping pixels beyond the end of the row.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module pixel_unpacker
    import uart_row_writer_pkg::*;
#(
    parameter int PIX_W  = 3,
    parameter int WIDTH  = 640,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic              load,
    input  logic [7:0]        byte_in,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data
);

    localparam int c_ppb = f_ppb(PIX_W);
    localparam int c_lw  = $clog2(WIDTH + 1);

    logic [7:0]        r_sh;
    logic [3:0]        r_rem;
    logic [ADDR_W-1:0] r_addr;
    logic [c_lw-1:0]   r_left;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;

    logic              w_emit;
    logic [PIX_W-1:0]  w_pix;

    assign w_emit = load || (r_rem != 4'd0);
    assign w_pix  = load ? byte_in[PIX_W-1:0] : r_sh[PIX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh      <= 8'd0;
            r_rem     <= 4'd0;
            r_addr    <= '0;
            r_left    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (start) begin
                r_addr <= base;
                r_left <= c_lw'(WIDTH);
                r_rem  <= 4'd0;
            end else begin
                if (load) begin
                    r_sh  <= byte_in >> PIX_W;
                    r_rem <= 4'(c_ppb - 1);
                end else if (r_rem != 4'd0) begin
                    r_sh  <= r_sh >> PIX_W;
                    r_rem <= r_rem - 4'd1;
                end
                // Padding pixels past the row end are consumed silently.
                if (w_emit && (r_left != '0)) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= w_pix;
                    r_addr    <= r_addr + 1'b1;
                    r_left    <= r_left - 1'b1;
                end
            end
        end
    end

    assign busy    = (r_rem != 4'd0);
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: rtl/uart_row_writer.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_row_writer                                              |
// | Description : Decodes [ROW_HI, ROW_LO, payload, (checksum), END] frames    |
// |               into framebuffer writes and returns one response per frame.  |
// |               Define ROW_CHECKSUM_EN to require an XOR checksum byte.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_row_writer
    import uart_row_writer_pkg::*;
#(
    parameter int         PIX_W    = 3,
    parameter int         WIDTH    = 640,
    parameter int         HEIGHT   = 480,
    parameter int         ADDR_W   = 19,
    parameter logic [7:0] END_CODE = 8'hFF,
    parameter int         TIMEOUT  = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic [7:0]        resp_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy,
    output logic              row_done
);

    localparam int c_nb = f_nb(WIDTH, PIX_W);
    localparam int c_tw = $clog2(TIMEOUT + 1);
`ifdef ROW_CHECKSUM_EN
    localparam state_t c_st_after = c_st_csum;
`else
    localparam state_t c_st_after = c_st_trailer;
`endif

    state_t            r_state;
    state_t            w_state_nx;
    logic [7:0]        r_row_hi;
    logic [15:0]       r_nb;
    logic [c_tw-1:0]   r_idle;
    logic              r_force;
    logic [7:0]        r_resp;

    logic              w_rdy;
    logic              w_acc;
    logic [15:0]       w_row;
    logic              w_row_bad;
    logic [ADDR_W-1:0] w_base;
    logic              w_cnt_state;
    logic              w_tick;
    logic              w_tmo;
    logic              w_last;
    logic              w_start;
    logic              w_load;
    logic              w_unp_busy;
    logic              w_resp_ld;
    logic [7:0]        w_resp_code;
    logic [7:0]        w_trl_code;

    assign w_row       = {r_row_hi, s_data};
    assign w_row_bad   = (w_row >= 16'(HEIGHT));
    assign w_base      = ADDR_W'(32'(w_row) * 32'(WIDTH));
    assign w_acc       = s_valid && w_rdy;
    assign w_last      = (r_nb == 16'(c_nb - 1));
    assign w_cnt_state = (r_state != c_st_idle) && (r_state != c_st_resp);
    assign w_tick      = w_cnt_state && w_rdy && !s_valid;
    assign w_tmo       = w_tick && (r_idle == c_tw'(TIMEOUT - 1));

`ifdef ROW_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum     <= 8'd0;
            r_csum_bad <= 1'b0;
        end else if (w_acc) begin
            if (r_state == c_st_idle) begin
                r_csum     <= s_data;
                r_csum_bad <= 1'b0;
            end else if (r_state == c_st_csum) begin
                r_csum_bad <= (s_data != r_csum);
            end else if (r_state != c_st_trailer) begin
                r_csum <= r_csum ^ s_data;
            end
        end
    end

    assign w_trl_code = r_force                ? c_resp_row  :
                        r_csum_bad             ? c_resp_csum :
                        (s_data == END_CODE)   ? c_resp_ack  : c_resp_end;
`else
    assign w_trl_code = r_force                ? c_resp_row  :
                        (s_data == END_CODE)   ? c_resp_ack  : c_resp_end;
`endif

    // Input is held off while the unpacker still owes pixels from the last byte.
    always_comb begin
        w_rdy = 1'b0;
        case (r_state)
            c_st_idle, c_st_row_lo, c_st_discard:   w_rdy = 1'b1;
            c_st_payload, c_st_csum, c_st_trailer:  w_rdy = !w_unp_busy;
            default:                                w_rdy = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_resp_ld   = 1'b0;
        w_resp_code = r_resp;
        w_start     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            c_st_idle:    if (w_acc) w_state_nx = c_st_row_lo;
            c_st_row_lo:  if (w_acc) begin
                              w_start    = 1'b1;
                              w_state_nx = w_row_bad ? c_st_discard : c_st_payload;
                          end
            c_st_payload: if (w_acc) begin
                              w_load = 1'b1;
                              if (w_last) w_state_nx = c_st_after;
                          end
            c_st_discard: if (w_acc && w_last) w_state_nx = c_st_after;
            c_st_csum:    if (w_acc) w_state_nx = c_st_trailer;
            c_st_trailer: if (w_acc) begin
                              w_state_nx  = c_st_resp;
                              w_resp_ld   = 1'b1;
                              w_resp_code = w_trl_code;
                          end
            c_st_resp:    if (resp_ready) w_state_nx = c_st_idle;
            default:      w_state_nx = c_st_idle;
        endcase
        if (w_tmo) begin
            w_state_nx  = c_st_resp;
            w_resp_ld   = 1'b1;
            w_resp_code = c_resp_tmo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_row_hi <= 8'd0;
            r_nb     <= 16'd0;
            r_idle   <= '0;
            r_force  <= 1'b0;
            r_resp   <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            if (w_resp_ld) r_resp <= w_resp_code;
            if (w_acc || !w_cnt_state) r_idle <= '0;
            else if (w_tick)           r_idle <= r_idle + 1'b1;
            if (w_acc) begin
                case (r_state)
                    c_st_idle: begin
                        r_row_hi <= s_data;
                        r_nb     <= 16'd0;
                        r_force  <= 1'b0;
                    end
                    c_st_row_lo:                r_force <= w_row_bad;
                    c_st_payload, c_st_discard: r_nb    <= r_nb + 16'd1;
                    default: ;
                endcase
            end
        end
    end

    pixel_unpacker #(
        .PIX_W  (PIX_W),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_unpacker (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .base    (w_base),
        .load    (w_load),
        .byte_in (s_data),
        .busy    (w_unp_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign s_ready    = w_rdy;
    assign resp_valid = (r_state == c_st_resp);
    assign resp_data  = r_resp;
    assign busy       = (r_state != c_st_idle);
    assign row_done   = (r_state == c_st_resp) && resp_ready && (r_resp == c_resp_ack);

endmodule

`default_nettype wire

// File: tb/tb_uart_row_writer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_row_writer                                           |
// | Description : Directed self-checking bench for uart_row_writer: a 640x480  |
// |               instance and a 5x4 instance exercising the partial last byte.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_row_writer;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        r_valid;
    logic        r_rready;
    logic        r_sel;

    logic        w_v1, w_v2, w_rr1, w_rr2;
    logic        w_rdy1, w_rdy2, w_we1, w_we2;
    logic [18:0] w_a1;
    logic [4:0]  w_a2;
    logic [2:0]  w_d1, w_d2;
    logic [7:0]  w_rd1, w_rd2;
    logic        w_rv1, w_rv2, w_bz1, w_bz2, w_dn1, w_dn2;

    logic        m_ready, m_wr_en, m_resp_valid, m_busy, m_row_done;
    logic [31:0] m_addr;
    logic [2:0]  m_data;
    logic [7:0]  m_resp_data;

    int          checks = 0;
    int          failures = 0;
    int          wr_total = 0;
    int          bad_total = 0;
    int          wr_start = 0;
    int          bad_start = 0;
    logic [31:0] exp_base = 0;
    logic [7:0]  pat = 0;
    bit          stalled = 0;

    assign w_v1  = r_valid && !r_sel;
    assign w_v2  = r_valid && r_sel;
    assign w_rr1 = r_rready && !r_sel;
    assign w_rr2 = r_rready && r_sel;

    assign m_ready      = r_sel ? w_rdy2 : w_rdy1;
    assign m_wr_en      = r_sel ? w_we2  : w_we1;
    assign m_addr       = r_sel ? 32'(w_a2) : 32'(w_a1);
    assign m_data       = r_sel ? w_d2   : w_d1;
    assign m_resp_valid = r_sel ? w_rv2  : w_rv1;
    assign m_resp_data  = r_sel ? w_rd2  : w_rd1;
    assign m_busy       = r_sel ? w_bz2  : w_bz1;
    assign m_row_done   = r_sel ? w_dn2  : w_dn1;

    uart_row_writer #(
        .PIX_W(3), .WIDTH(640), .HEIGHT(480), .ADDR_W(19), .END_CODE(8'hFF), .TIMEOUT(64)
    ) u_big (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(w_v1), .s_ready(w_rdy1),
        .wr_en(w_we1), .wr_addr(w_a1), .wr_data(w_d1), .resp_data(w_rd1),
        .resp_valid(w_rv1), .resp_ready(w_rr1), .busy(w_bz1), .row_done(w_dn1)
    );

    uart_row_writer #(
        .PIX_W(3), .WIDTH(5), .HEIGHT(4), .ADDR_W(5), .END_CODE(8'hFF), .TIMEOUT(64)
    ) u_small (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(w_v2), .s_ready(w_rdy2),
        .wr_en(w_we2), .wr_addr(w_a2), .wr_data(w_d2), .resp_data(w_rd2),
        .resp_valid(w_rv2), .resp_ready(w_rr2), .busy(w_bz2), .row_done(w_dn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pixel for write index i: even -> byte[2:0], odd -> byte[5:3].
    always @(negedge clk) begin
        if (m_wr_en) begin
            int idx;
            idx = wr_total - wr_start;
            if (m_addr !== exp_base + 32'(idx) ||
                m_data !== (idx[0] ? pat[5:3] : pat[2:0]))
                bad_total++;
            wr_total++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {27'd0, m_ready, m_wr_en, m_resp_valid, m_busy, m_row_done}, 32'b10000);
        chk({tag, "_addr"}, m_addr, 32'd0);
        chk({tag, "_data"}, {29'd0, m_data}, 32'd0);
        chk({tag, "_resp"}, {24'd0, m_resp_data}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        if (!stalled) begin
            s_data  = b;
            r_valid = 1'b1;
            n = 0;
            while (!m_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!m_ready) begin
                stalled = 1;
                chk("send_ready", {31'd0, m_ready}, 32'd1);
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic arm(input bit s, input logic [7:0] p, input logic [31:0] base);
        r_sel     = s;
        pat       = p;
        exp_base  = base;
        wr_start  = wr_total;
        bad_start = bad_total;
    endtask

    task automatic frame(input bit s, input logic [15:0] row, input logic [7:0] p, input int nb,
                         input logic [7:0] trl, input bit bad_cs, input logic [31:0] base);
        logic [7:0] cs;
        arm(s, p, base);
        cs = row[15:8] ^ row[7:0];
        send(row[15:8]);
        send(row[7:0]);
        for (int i = 0; i < nb; i++) begin
            send(p);
            cs = cs ^ p;
        end
`ifdef ROW_CHECKSUM_EN
        send(bad_cs ? ~cs : cs);
`else
        if (bad_cs) cs = ~cs;
`endif
        send(trl);
        r_valid = 1'b0;
    endtask

    task automatic wait_resp(input int lim, input logic [7:0] code, input string tag, output logic rd);
        int n;
        n  = 0;
        rd = 1'b0;
        while (!m_resp_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, m_resp_valid}, 32'd1);
        if (m_resp_valid) begin
            chk({tag, "_code"}, {24'd0, m_resp_data}, {24'd0, code});
            r_rready = 1'b1;
            #1 rd = m_row_done;
            @(posedge clk);
            @(negedge clk);
            r_rready = 1'b0;
        end
    endtask

    task automatic chk_writes(input string tag, input int n);
        chk({tag, "_wr_cnt"}, 32'(wr_total - wr_start), 32'(n));
        chk({tag, "_wr_bad"}, 32'(bad_total - bad_start), 32'd0);
    endtask

    initial begin
        logic rd;
        logic stable;
        rst = 1'b1; s_data = 8'd0; r_valid = 1'b0; r_rready = 1'b0; r_sel = 1'b0;
        #1;
        chk_reset("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Row 2: first pixel one cycle after accept, then full row.
        arm(0, 8'h0A, 32'd1280);
        send(8'h00);
        send(8'h02);
        send(8'h0A);
        chk("lat_wr_en", {31'd0, m_wr_en}, 32'd1);
        chk("lat_addr", m_addr, 32'd1280);
        chk("lat_data", {29'd0, m_data}, 32'd2);
        chk("lat_ready", {31'd0, m_ready}, 32'd0);
        for (int i = 1; i < 320; i++) send(8'h0A);
`ifdef ROW_CHECKSUM_EN
        send(8'h02);
`endif
        send(8'hFF);
        r_valid = 1'b0;
        wait_resp(20, 8'hAA, "row2", rd);
        chk_writes("row2", 640);
        chk("row2_done", {31'd0, rd}, 32'd1);

        frame(0, 16'd480, 8'h0A, 320, 8'hFF, 0, 32'd0);
        wait_resp(20, 8'hE1, "row480", rd);
        chk_writes("row480", 0);
        chk("row480_done", {31'd0, rd}, 32'd0);

        frame(0, 16'd0, 8'h0A, 320, 8'h00, 0, 32'd0);
        wait_resp(20, 8'hE2, "badend", rd);
        chk_writes("badend", 640);
        chk("badend_done", {31'd0, rd}, 32'd0);

        // Stall after ten payload bytes.
        arm(0, 8'h0A, 32'd1920);
        send(8'h00);
        send(8'h03);
        for (int i = 0; i < 10; i++) send(8'h0A);
        r_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("tmo_early", {31'd0, m_resp_valid}, 32'd0);
        wait_resp(60, 8'hE3, "tmo", rd);
        chk_writes("tmo", 20);

        frame(0, 16'd1, 8'h0A, 320, 8'hFF, 0, 32'd640);
        wait_resp(20, 8'hAA, "after_tmo", rd);
        chk_writes("after_tmo", 640);

        // Response held for 50 cycles with a new byte already offered.
        frame(0, 16'd4, 8'h2C, 320, 8'hFF, 0, 32'd2560);
        s_data = 8'h00;
        r_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(m_resp_valid === 1'b1 && m_resp_data === 8'hAA && m_ready === 1'b0)) stable = 1'b0;
        end
        chk("hold_stable", {31'd0, stable}, 32'd1);
        chk_writes("hold", 640);
        arm(0, 8'h0A, 32'd3200);
        r_rready = 1'b1;
        #1 chk("hold_done", {31'd0, m_row_done}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        r_rready = 1'b0;
        chk("handoff_idle", {30'd0, m_busy, m_ready}, 32'b01);
        @(posedge clk);
        @(negedge clk);
        chk("handoff_taken", {31'd0, m_busy}, 32'd1);

        // Reset in the middle of the payload of row 5.
        send(8'h05);
        send(8'h0A);
        send(8'h0A);
        chk("pre_rst_wr", {31'd0, m_wr_en}, 32'd1);
        rst = 1'b1;
        r_valid = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        frame(0, 16'd7, 8'h0A, 320, 8'hFF, 0, 32'd4480);
        wait_resp(20, 8'hAA, "post_rst", rd);
        chk_writes("post_rst", 640);

`ifdef ROW_CHECKSUM_EN
        frame(0, 16'd6, 8'h0A, 320, 8'hFF, 1, 32'd3840);
        wait_resp(20, 8'hE4, "csum", rd);
        chk_writes("csum", 640);
        chk("csum_done", {31'd0, rd}, 32'd0);
`endif

        // 5-pixel rows: the second pixel of the third byte is padding.
        frame(1, 16'd1, 8'h0A, 3, 8'hFF, 0, 32'd5);
        wait_resp(20, 8'hAA, "small1", rd);
        chk_writes("small1", 5);
        chk("small1_done", {31'd0, rd}, 32'd1);

        frame(1, 16'd3, 8'h2C, 3, 8'hFF, 0, 32'd15);
        wait_resp(20, 8'hAA, "small3", rd);
        chk_writes("small3", 5);

        frame(1, 16'd4, 8'h2C, 3, 8'hFF, 0, 32'd0);
        wait_resp(20, 8'hE1, "small4", rd);
        chk_writes("small4", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
